// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//   Round-robin arbiter sharing one I2C master among N sensor sequencers.
//   A requester owns the bus for a whole transaction (while it holds req).
//   Master responses are routed only to the owner, and a watchdog
//   force-releases an owner that sees no sended/received pulse for TIMEOUT
//   cycles. A timed-out requester is locked out until it drops req.
//
// Handshake: a requester raises req and holds it until its transaction is
//   complete; gnt (registered, one-hot or zero) marks ownership. While
//   granted, the owner's start/send/receive/datasend drive the master
//   combinationally and the master's sended/received come back on the
//   owner's bit only. Dropping req ends ownership on the next edge.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req[N]                per-requester bus request
//   gnt[N]                registered one-hot grant
//   start_in/send_in/receive_in[N], datasend_in[8N]   requester -> master
//   sended_out/received_out[N]  master responses routed to owner
//   datareceive_out[8]    master read data, broadcast
//   start/send/receive/datasend  to master
//   sended/received/datareceive/ready  from master
//   timeout, timeout_id   forced-release pulse and last timed-out index
//   state_o               FSM state (0 IDLE, 1 OWN, 2 DRAIN) for observation
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 100000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    input  logic [N-1:0]   start_in,
    input  logic [N-1:0]   send_in,
    input  logic [N-1:0]   receive_in,
    input  logic [8*N-1:0] datasend_in,
    output logic [N-1:0]   sended_out,
    output logic [N-1:0]   received_out,
    output logic [7:0]     datareceive_out,
    output logic           start,
    output logic           send,
    output logic           receive,
    output logic [7:0]     datasend,
    input  logic           sended,
    input  logic           received,
    input  logic [7:0]     datareceive,
    input  logic           ready,
    output logic           timeout,
    output logic [2:0]     timeout_id,
    output logic [1:0]     state_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state_q;
    logic [2:0]     owner_q;
    logic [2:0]     last_q;
    logic [N-1:0]   lockout_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   gnt_q;
    logic           timeout_q;
    logic [2:0]     timeout_id_q;

    logic           pick_valid_d;
    logic [2:0]     pick_idx_d;
    logic [N-1:0]   pick_oh_d;
    logic           owner_req;
    logic           resp;

    // Rotating priority: scan from the farthest offset to the nearest so the
    // first eligible index after last_q is the one left standing.
    always_comb begin
        pick_valid_d = 1'b0;
        pick_idx_d   = 3'd0;
        pick_oh_d    = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (((int'(last_q) + k) % N) == i && req[i] && !lockout_q[i]) begin
                    pick_valid_d = 1'b1;
                    pick_idx_d   = i[2:0];
                    pick_oh_d    = '0;
                    pick_oh_d[i] = 1'b1;
                end
            end
        end
    end

    // gnt_q is one-hot exactly while in OWN, so it doubles as the owner mask.
    assign owner_req = |(req & gnt_q);
    assign resp      = sended | received;

    always_comb begin
        start    = 1'b0;
        send     = 1'b0;
        receive  = 1'b0;
        datasend = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (state_q == ST_OWN && gnt_q[i]) begin
                start    = start_in[i];
                send     = send_in[i];
                receive  = receive_in[i];
                datasend = datasend_in[8*i +: 8];
            end
        end
    end

    assign sended_out      = (state_q == ST_OWN) ? (gnt_q & {N{sended}})   : '0;
    assign received_out    = (state_q == ST_OWN) ? (gnt_q & {N{received}}) : '0;
    assign datareceive_out = datareceive;
    assign gnt             = gnt_q;
    assign timeout         = timeout_q;
    assign timeout_id      = timeout_id_q;
    assign state_o         = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 3'd0;
            last_q       <= 3'(N - 1);
            lockout_q    <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= 3'd0;
        end else begin
            timeout_q <= 1'b0;
            lockout_q <= lockout_q & req;
            case (state_q)
                ST_IDLE: begin
                    if (ready && pick_valid_d) begin
                        owner_q <= pick_idx_d;
                        gnt_q   <= pick_oh_d;
                        cnt_q   <= '0;
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    cnt_q <= resp ? '0 : cnt_q + 1'b1;
                    // A voluntary release takes precedence over expiry.
                    if (!owner_req) begin
                        gnt_q   <= '0;
                        last_q  <= owner_q;
                        state_q <= ST_DRAIN;
                    end else if (cnt_q == CW'(TIMEOUT - 1) && !resp) begin
                        timeout_q    <= 1'b1;
                        timeout_id_q <= owner_q;
                        lockout_q    <= (lockout_q & req) | gnt_q;
                        gnt_q        <= '0;
                        last_q       <= owner_q;
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   start_in, send_in, receive_in;
    logic [8*N-1:0] datasend_in;
    logic [N-1:0]   sended_out, received_out;
    logic [7:0]     datareceive_out;
    logic           start, send, receive;
    logic [7:0]     datasend;
    logic           sended, received;
    logic [7:0]     datareceive;
    logic           ready;
    logic           timeout;
    logic [2:0]     timeout_id;
    logic [1:0]     state_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    i2c_bus_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .start_in(start_in), .send_in(send_in), .receive_in(receive_in),
        .datasend_in(datasend_in), .sended_out(sended_out),
        .received_out(received_out), .datareceive_out(datareceive_out),
        .start(start), .send(send), .receive(receive), .datasend(datasend),
        .sended(sended), .received(received), .datareceive(datareceive),
        .ready(ready), .timeout(timeout), .timeout_id(timeout_id),
        .state_o(state_o)
    );

    // driver: advance one clock, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; start_in = '0; send_in = '0; receive_in = '0;
        datasend_in = '0; sended = 1'b0; received = 1'b0; datareceive = 8'h00;
        ready = 1'b1;
        step(); step();
        check("rst_gnt", gnt, 0);
        check("rst_state", state_o, 0);
        check("rst_timeout", timeout, 0);
        check("rst_tid", timeout_id, 0);
        check("rst_send", send, 0);
        check("rst_datasend", datasend, 0);

        // single requester
        reset = 1'b0;
        step();
        req = 2'b01;
        step();
        check("single_gnt", gnt, 2'b01);
        check("single_state", state_o, 1);
        send_in = 2'b01; datasend_in[7:0] = 8'hEE; #1;
        check("single_send", send, 1);
        check("single_datasend", datasend, 8'hEE);
        sended = 1'b1; #1;
        check("single_sended_out", sended_out, 2'b01);
        check("single_received_out", received_out, 2'b00);
        datareceive = 8'h9A; #1;
        check("single_datareceive", datareceive_out, 8'h9A);
        step();
        sended = 1'b0; send_in = '0;
        req = 2'b00;
        step();
        check("single_rel_gnt", gnt, 0);
        check("single_drain", state_o, 2);
        check("single_drain_send", send, 0);
        step();
        check("single_idle", state_o, 0);

        // isolation: requester 1 strobes while 0 owns
        req = 2'b01;
        step();
        check("iso_gnt", gnt, 2'b01);
        req = 2'b11; send_in = 2'b10; datasend_in = {8'h55, 8'hA1}; #1;
        check("iso_send", send, 0);
        check("iso_datasend", datasend, 8'hA1);
        sended = 1'b1; #1;
        check("iso_sended_out", sended_out, 2'b01);
        sended = 1'b0;
        req = 2'b10;
        step();
        check("iso_rel", gnt, 0);
        step();
        step();
        check("iso_gnt1", gnt, 2'b10);
        send_in = '0;
        req = 2'b00;
        step(); step();
        check("iso_idle", state_o, 0);

        // contention from reset: 0,1,0,1
        reset = 1'b1; req = 2'b11;
        step();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) exp_q.push_back((t % 2 == 0) ? 2'b01 : 2'b10);
        for (int t = 0; t < 4; t++) begin
            step();
            check("cont_gnt", gnt, exp_q.pop_front());
            req = 2'b11 & ~gnt;
            step();
            check("cont_rel", gnt, 0);
            req = 2'b11;
            step();
            check("cont_not_both", gnt, 0);
        end
        req = 2'b00;
        step();

        // watchdog (last owner is 1, so 0 is next)
        req = 2'b01;
        step();
        check("wd_gnt", gnt, 2'b01);
        for (int c = 0; c < TO - 1; c++) begin
            step();
            check("wd_no_timeout", timeout, 0);
        end
        check("wd_still_owned", gnt, 2'b01);
        step();
        check("wd_timeout", timeout, 1);
        check("wd_tid", timeout_id, 0);
        check("wd_gnt_cleared", gnt, 0);
        step();
        check("wd_pulse_end", timeout, 0);
        check("wd_idle", state_o, 0);
        req = 2'b11;
        step();
        check("wd_other_gnt", gnt, 2'b10);
        req = 2'b01;
        step(); step(); step();
        check("wd_locked", gnt, 0);
        req = 2'b00;
        step();
        req = 2'b01;
        step();
        check("wd_regrant", gnt, 2'b01);

        // received on the expiry cycle clears the counter
        for (int c = 0; c < TO - 1; c++) begin
            step();
            check("bnd_no_timeout", timeout, 0);
        end
        received = 1'b1; #1;
        check("bnd_received_out", received_out, 2'b01);
        step();
        received = 1'b0;
        check("bnd_rx_timeout", timeout, 0);
        check("bnd_rx_gnt", gnt, 2'b01);

        // req drop on the expiry cycle is a normal release
        for (int c = 0; c < TO - 1; c++) step();
        req = 2'b00;
        step();
        check("bnd_drop_timeout", timeout, 0);
        check("bnd_drop_gnt", gnt, 0);
        check("bnd_drop_state", state_o, 2);
        step();
        req = 2'b01;
        step();
        check("bnd_after_gnt", gnt, 2'b01);

        // reset mid-transaction
        send_in = 2'b01; datasend_in[7:0] = 8'h3C; #1;
        check("mid_send", send, 1);
        check("mid_datasend", datasend, 8'h3C);
        reset = 1'b1;
        step();
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_send", send, 0);
        check("mid_rst_datasend", datasend, 0);
        check("mid_rst_state", state_o, 0);
        check("mid_rst_timeout", timeout, 0);
        reset = 1'b0; send_in = '0; req = 2'b11;
        step();
        check("mid_rst_first", gnt, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter that shares one I2C_MASTER instance among N sensor sequencers (BMP180 and future I2C sensor clients). It sits between the requesters and the master's start/send/receive handshake. It grants the bus to one requester for a whole transaction, routes the master's responses only to the owner, and force-releases a hung owner with a watchdog.

## Interface
Parameters:
- N, 2: number of requesters; legal range 2..8.
- TIMEOUT, 100000: clk cycles an owner may hold the bus without a sended/received pulse before forced release; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester bus request; held high for the whole transaction.
- gnt  out  N  one-hot (or zero) grant, registered.
- start_in  in  N  per-requester start to master.
- send_in  in  N  per-requester send strobe.
- receive_in  in  N  per-requester receive strobe.
- datasend_in  in  8*N  requester i byte at bits [8i+7:8i].
- sended_out  out  N  master sended, routed to owner only.
- received_out  out  N  master received, routed to owner only.
- datareceive_out  out  8  master datareceive, broadcast unmodified.
- start, send, receive  out  1 each  to master.
- datasend  out  8  to master.
- sended, received  in  1 each  from master.
- datareceive  in  8  from master.
- ready  in  1  master idle/ready.
- timeout  out  1  one-cycle pulse on forced release.
- timeout_id  out  3  index of the last timed-out requester; holds until the next timeout.

## Operation
- Registered state: IDLE, OWN, DRAIN. Also: owner index, last-owner pointer, lockout[N], watchdog counter of width clog2(TIMEOUT+1).
- IDLE:
  - gnt=0.
  - If ready=1 and any eligible req, pick the first eligible index after the last owner, wrapping modulo N.
  - Eligible means req[i]=1 and lockout[i]=0.
  - Load owner, set gnt[owner], clear the counter, go to OWN.
- OWN:
  - start/send/receive/datasend = owner's inputs (combinational mux).
  - sended_out[owner]=sended and received_out[owner]=received; all other bits are 0.
  - Counter increments each cycle and clears on any cycle with sended|received.
  - If req[owner]=0: go to DRAIN, clear gnt, last=owner.
  - Else if counter reaches TIMEOUT-1 with no sended|received this cycle: pulse timeout, set timeout_id=owner and lockout[owner]=1, clear gnt, last=owner, go to DRAIN.
- DRAIN:
  - Master-side start/send/receive/datasend forced 0.
  - When ready=1, go to IDLE.
- Outside OWN: master-side outputs are 0 and sended_out/received_out are 0.
- lockout[i] clears on any cycle with req[i]=0.
- Simultaneous events:
  - Owner drop of req and watchdog expiry in the same cycle: normal release, no timeout pulse, no lockout.
  - sended|received on the expiry cycle: counter clears, no timeout.
- Requests arriving during OWN/DRAIN wait. A request pulse shorter than the grant latency is lost; requesters must hold req.

## Timing
- Reset values: gnt=0, start=send=receive=0, datasend=0, sended_out=received_out=0, timeout=0, timeout_id=0, state=IDLE, last=N-1 (requester 0 wins first), lockout=0, counter=0.
- Reset mid-transaction aborts the grant immediately on the next edge. The master is reset by the same signal.
- Grant latency: req sampled high in IDLE with ready=1 at edge k gives gnt high after edge k (1 cycle).
- Release: req low sampled at edge k gives gnt low after edge k. DRAIN lasts ≥1 cycle. The next grant comes ≥2 cycles after DRAIN is entered.
- Owner-to-master strobes and master-to-owner responses are combinational: zero added latency.
- Timeout fires exactly TIMEOUT cycles after the last sended/received, or after grant, with no intervening pulse.

## Test plan
- Single requester: req[0]=1 at cycle 5 with ready=1 → gnt=01 at cycle 6. Send 0xEE → datasend=0xEE. The sended pulse appears only on sended_out[0]. Drop req → gnt=00 next cycle, DRAIN, back to IDLE.
- Contention, N=2: req=11 from reset → grant order 0,1,0,1 across four back-to-back transactions. No cycle has gnt=11.
- Isolation: while requester 0 owns the bus, requester 1 toggles send_in[1] with datasend 0x55 → master send/datasend stay owner's values. sended_out[1]=0 throughout.
- Watchdog, TIMEOUT=16: owner holds req with no master response → timeout pulse 16 cycles after grant, timeout_id=0, gnt=00. Requester 0 is not regranted until req[0] drops and rises again. Requester 1 is granted meanwhile.
- Boundary: a received pulse on cycle 15 of 16 resets the counter with no timeout. A req drop coinciding with expiry gives no timeout pulse.
- Reset asserted mid-OWN with send high → all outputs at reset values after one edge. After reset, requester 0 is served first.
